// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
//
// A WIDTH-bit add is split into N = WIDTH/CHUNK lookahead chunks. Chunk k is
// computed in pipeline stage k, and the chunk carry is registered between
// stages. WIDTH must be a multiple of CHUNK. Accepts one operation per cycle
// under a valid/ready handshake, with full backpressure. Empty stages collapse,
// so a bubble is filled even while the output is stalled.
//
// Optional feature: define PCLA_OVF_EN to add the 'ovf' output. It reports the
// two's-complement signed overflow of the completed operation.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset; discards in-flight operations
//   in_valid   operands presented
//   in_ready   block can accept this cycle (0 while reset=1)
//   a, b       operands
//   ci         carry-in (borrow-in when sub=1)
//   sub        0: a+b+ci, 1: a-b-ci (computed as a+~b+~ci)
//   out_valid  result available
//   out_ready  downstream accepts result
//   s          sum/difference, modulo 2^WIDTH
//   co         raw carry out of MSB (sub: 1 = no borrow)
//   ovf        signed overflow (PCLA_OVF_EN only)
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef PCLA_OVF_EN
  output logic             ovf,
`endif
  output logic             co
);

  localparam int unsigned N = WIDTH / CHUNK;

  // One lookahead chunk. Each carry is a flat sum of generate/propagate
  // products, so no carry ripples through the chunk.
  // Returns {carry into chunk MSB, carry out, sum}.
  function automatic logic [CHUNK+1:0] cla_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             t;
    logic             gt;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      t = cin;
      for (int j = 0; j <= i; j++) t = t & p[j];
      for (int j = 0; j <= i; j++) begin
        gt = g[j];
        for (int m = j + 1; m <= i; m++) gt = gt & p[m];
        t = t | gt;
      end
      c[i+1] = t;
    end
    return {c[CHUNK-1], c[CHUNK], p ^ c[CHUNK-1:0]};
  endfunction

  // Stage state: valid, chunk carry, result bits so far, and the operands
  // (b already conditionally inverted) carried along for later chunks.
  logic [N-1:0]            v_q,   v_d;
  logic [N-1:0]            c_q,   c_d;
  logic [N-1:0][WIDTH-1:0] res_q, res_d;
  logic [N-1:0][WIDTH-1:0] opa_q, opa_d;
  logic [N-1:0][WIDTH-1:0] opb_q, opb_d;
`ifdef PCLA_OVF_EN
  logic                    ovf_q, ovf_d;
`endif

  logic [N-1:0]     adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             in_fire;

  // Per-stage chunk inputs and results.
  logic [CHUNK-1:0] cx   [N];
  logic [CHUNK-1:0] cy   [N];
  logic             ccin [N];
  logic [CHUNK+1:0] cres [N];
  logic [N-1:0]     cmsb;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = ci ^ sub;

  for (genvar k = 0; k < N; k++) begin : g_chunk
    if (k == 0) begin : g_first
      assign cx[k]   = a[CHUNK-1:0];
      assign cy[k]   = b_eff[CHUNK-1:0];
      assign ccin[k] = cin_eff;
    end else begin : g_rest
      assign cx[k]   = opa_q[k-1][k*CHUNK +: CHUNK];
      assign cy[k]   = opb_q[k-1][k*CHUNK +: CHUNK];
      assign ccin[k] = c_q[k-1];
    end
    assign cres[k] = cla_chunk(cx[k], cy[k], ccin[k]);
    assign cmsb[k] = cres[k][CHUNK+1];
  end

  // Advance chain: a stage may load if it is empty or its contents move on.
  always_comb begin
    adv        = '0;
    adv[N-1]   = ~v_q[N-1] | out_ready;
    for (int k = int'(N) - 2; k >= 0; k--) begin
      adv[k] = ~v_q[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0] & ~reset;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    v_d   = v_q;
    c_d   = c_q;
    res_d = res_q;
    opa_d = opa_q;
    opb_d = opb_q;
`ifdef PCLA_OVF_EN
    ovf_d = ovf_q;
`endif

    // Data registers only load with a real operation, so bubbles leave the
    // last result in place instead of propagating junk.
    if (adv[0]) begin
      v_d[0] = in_fire;
      if (in_fire) begin
        c_d[0]              = cres[0][CHUNK];
        res_d[0]            = '0;
        res_d[0][CHUNK-1:0] = cres[0][CHUNK-1:0];
        opa_d[0]            = a;
        opb_d[0]            = b_eff;
`ifdef PCLA_OVF_EN
        if (N == 1) ovf_d = cres[0][CHUNK+1] ^ cres[0][CHUNK];
`endif
      end
    end

    for (int k = 1; k < int'(N); k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          c_d[k]                     = cres[k][CHUNK];
          res_d[k]                   = res_q[k-1];
          res_d[k][k*CHUNK +: CHUNK] = cres[k][CHUNK-1:0];
          opa_d[k]                   = opa_q[k-1];
          opb_d[k]                   = opb_q[k-1];
`ifdef PCLA_OVF_EN
          if (k == int'(N) - 1) ovf_d = cres[k][CHUNK+1] ^ cres[k][CHUNK];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      c_q   <= '0;
      res_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
`ifdef PCLA_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      res_q <= res_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
`ifdef PCLA_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign out_valid = v_q[N-1];
  assign s         = res_q[N-1];
  assign co        = c_q[N-1];
`ifdef PCLA_OVF_EN
  assign ovf       = ovf_q;
`endif

  // Already-consumed operand bits and unneeded chunk MSB carries are
  // intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{opa_q, opb_q, cmsb};

endmodule
